// File: rtl/lock_sequencer.sv
// Entry and policy controller for the 4-digit combination lock.
// Collects four digits, judges the whole entry, and handles lockout and auto-relock.
module lock_sequencer #(
    parameter logic [15:0] COMBO          = 16'h8421,
    parameter int unsigned MAX_FAILS      = 3,
    parameter logic [31:0] LOCKOUT_CYCLES = 32'd250000000,
    parameter logic [31:0] OPEN_CYCLES    = 32'd500000000,
    parameter logic [31:0] ENTRY_CYCLES   = 32'd500000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       relock,
    output logic       open,
    output logic       locked_out,
    output logic       fail,
    output logic [2:0] digits_in,
    output logic [3:0] fails,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_CHECK   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] timer;
    logic        mismatch;
    logic [3:0]  expected_c;
    logic [3:0]  fails_inc_c;

    // Combination nibble for the digit position about to be entered.
    always_comb begin
        expected_c = COMBO[15:12];
        case (digits_in[1:0])
            2'd0:    expected_c = COMBO[15:12];
            2'd1:    expected_c = COMBO[11:8];
            2'd2:    expected_c = COMBO[7:4];
            default: expected_c = COMBO[3:0];
        endcase
    end

    assign fails_inc_c = (fails == 4'hF) ? fails : fails + 4'd1;
    assign state       = state_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_ENTRY;
            open       <= 1'b0;
            locked_out <= 1'b0;
            fail       <= 1'b0;
            digits_in  <= 3'd0;
            fails      <= 4'd0;
            timer      <= 32'd0;
            mismatch   <= 1'b0;
        end else begin
            fail <= 1'b0;
            unique case (state_q)
                ST_ENTRY: begin
                    if (digit_valid) begin
                        mismatch  <= mismatch | (digit != expected_c);
                        digits_in <= digits_in + 3'd1;
                        timer     <= ENTRY_CYCLES;
                        if (digits_in == 3'd3) begin
                            state_q <= ST_CHECK;
                        end
                    end else if (digits_in != 3'd0) begin
                        // Abandoned partial entry: silently discarded, not a failure.
                        if (timer == 32'd0) begin
                            digits_in <= 3'd0;
                            mismatch  <= 1'b0;
                        end else begin
                            timer <= timer - 32'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    digits_in <= 3'd0;
                    mismatch  <= 1'b0;
                    if (!mismatch) begin
                        state_q <= ST_OPEN;
                        open    <= 1'b1;
                        fails   <= 4'd0;
                        timer   <= OPEN_CYCLES - 32'd1;
                    end else begin
                        fail  <= 1'b1;
                        fails <= fails_inc_c;
                        if (fails_inc_c == 4'(MAX_FAILS)) begin
                            state_q    <= ST_LOCKOUT;
                            locked_out <= 1'b1;
                            timer      <= LOCKOUT_CYCLES - 32'd1;
                        end else begin
                            state_q <= ST_ENTRY;
                            timer   <= ENTRY_CYCLES;
                        end
                    end
                end
                ST_OPEN: begin
                    if (relock || timer == 32'd0) begin
                        state_q <= ST_ENTRY;
                        open    <= 1'b0;
                        timer   <= ENTRY_CYCLES;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer == 32'd0) begin
                        state_q    <= ST_ENTRY;
                        locked_out <= 1'b0;
                        fails      <= 4'd0;
                        timer      <= ENTRY_CYCLES;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed scenarios plus a random soak, every cycle
// compared against a deadline/queue based model of the lock policy.
module tb_lock_sequencer;

    localparam logic [15:0] COMBO     = 16'h8421;
    localparam int          MAX_FAILS = 3;
    localparam int          LOCK_CYC  = 20;
    localparam int          OPEN_CYC  = 30;
    localparam int          ENTRY_CYC = 40;

    logic       CLOCK_50;
    logic       reset;
    logic       digit_valid;
    logic [3:0] digit;
    logic       relock;
    logic       open;
    logic       locked_out;
    logic       fail;
    logic [2:0] digits_in;
    logic [3:0] fails;
    logic [1:0] state;

    lock_sequencer #(
        .COMBO         (COMBO),
        .MAX_FAILS     (MAX_FAILS),
        .LOCKOUT_CYCLES(32'(LOCK_CYC)),
        .OPEN_CYCLES   (32'(OPEN_CYC)),
        .ENTRY_CYCLES  (32'(ENTRY_CYC))
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .digit_valid(digit_valid),
        .digit      (digit),
        .relock     (relock),
        .open       (open),
        .locked_out (locked_out),
        .fail       (fail),
        .digits_in  (digits_in),
        .fails      (fails),
        .state      (state)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    // Model: mode 0..3 = ENTRY/CHECK/OPEN/LOCKOUT, entered digits kept in a queue,
    // timeouts kept as absolute cycle deadlines.
    int         cyc = 0;
    int         m_mode = 0;
    logic [3:0] q[$];
    int         last_dig = 0;
    int         deadline = 0;
    int         m_fails = 0;
    bit         m_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit dv, input logic [3:0] d, input bit rl);
        logic [15:0] entered;
        m_fail = 1'b0;
        if (r) begin
            m_mode  = 0;
            q.delete();
            m_fails = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (dv) begin
                        q.push_back(d);
                        last_dig = cyc;
                        if (q.size() == 4) m_mode = 1;
                    end else if (q.size() > 0 && cyc - last_dig > ENTRY_CYC) begin
                        q.delete();
                    end
                end
                1: begin
                    entered = {q[0], q[1], q[2], q[3]};
                    q.delete();
                    if (entered == COMBO) begin
                        m_mode   = 2;
                        m_fails  = 0;
                        deadline = cyc + OPEN_CYC;
                    end else begin
                        m_fail = 1'b1;
                        if (m_fails < 15) m_fails++;
                        if (m_fails == MAX_FAILS) begin
                            m_mode   = 3;
                            deadline = cyc + LOCK_CYC;
                        end else begin
                            m_mode = 0;
                        end
                    end
                end
                2: if (rl || cyc >= deadline) m_mode = 0;
                default: begin
                    if (cyc >= deadline) begin
                        m_mode  = 0;
                        m_fails = 0;
                    end
                end
            endcase
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_mode));
        chk("open", 32'(open), 32'(m_mode == 2));
        chk("locked_out", 32'(locked_out), 32'(m_mode == 3));
        chk("fail", 32'(fail), 32'(m_fail));
        chk("digits_in", 32'(digits_in), 32'(q.size()));
        chk("fails", 32'(fails), 32'(m_fails));
    endtask

    task automatic step(input bit r, input bit dv, input logic [3:0] d, input bit rl);
        reset       = r;
        digit_valid = dv;
        digit       = d;
        relock      = rl;
        @(posedge CLOCK_50);
        model_step(r, dv, d, rl);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    // Four strobes with random idle gaps (never long enough to abandon).
    task automatic enter(input logic [15:0] code, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, code[15-4*i -: 4], 1'b0);
            if (i < 3) idle(int'($urandom_range(0, max_gap)));
        end
    endtask

    function automatic logic [15:0] wrong_code();
        logic [15:0] c;
        c = 16'($urandom);
        if (c == COMBO) c = c ^ 16'h0001;
        return c;
    endfunction

    initial begin
        reset = 1'b1; digit_valid = 1'b0; digit = 4'd0; relock = 1'b0;

        // Reset values.
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 4'd8, 1'b1);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_digits", 32'(digits_in), 32'd0);

        // Correct entry: CHECK then open, auto-relock after the open period.
        idle(2);
        enter(COMBO, 3);
        chk("check_state", 32'(state), 32'd1);
        chk("check_digits", 32'(digits_in), 32'd4);
        idle(1);
        chk("open_first", 32'(open), 32'd1);
        idle(OPEN_CYC - 1);
        chk("open_last", 32'(open), 32'd1);
        idle(1);
        chk("open_expired", 32'(open), 32'd0);

        // Wrong last digit: one fail pulse, back to ENTRY.
        enter({COMBO[15:4], 4'd0}, 2);
        idle(1);
        chk("wrong_fail", 32'(fail), 32'd1);
        chk("wrong_fails", 32'(fails), 32'd1);
        idle(1);
        chk("wrong_pulse_end", 32'(fail), 32'd0);

        // Back-to-back wrong entries until lockout; strobes and relock ignored there.
        for (int n = 0; n < 5 && m_mode != 3; n++) begin
            enter(wrong_code(), 0);
            idle(1);
        end
        chk("lockout_on", 32'(locked_out), 32'd1);
        for (int n = 0; n < 100 && m_mode == 3; n++)
            step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
        chk("lockout_end_state", 32'(state), 32'd0);
        chk("lockout_end_fails", 32'(fails), 32'd0);

        // Partial entry abandoned after the idle gap.
        step(1'b0, 1'b1, 4'd8, 1'b0);
        step(1'b0, 1'b1, 4'd4, 1'b0);
        idle(ENTRY_CYC);
        chk("abandon_pending", 32'(digits_in), 32'd2);
        idle(1);
        chk("abandon_done", 32'(digits_in), 32'd0);
        idle(3);

        // Relock coinciding with the final open cycle.
        enter(COMBO, 1);
        for (int n = 0; n < 100 && m_mode != 0; n++)
            step(1'b0, 1'b0, 4'd0, 1'(m_mode == 2 && cyc == deadline));
        chk("relock_expiry", 32'(open), 32'd0);

        // Early relock while open.
        enter(COMBO, 1);
        idle(6);
        step(1'b0, 1'b1, 4'd8, 1'b1);
        chk("relock_early", 32'(open), 32'd0);

        // Reset mid-entry.
        enter(COMBO, 0);
        idle(OPEN_CYC + 2);
        step(1'b0, 1'b1, 4'd8, 1'b0);
        step(1'b0, 1'b1, 4'd4, 1'b0);
        step(1'b0, 1'b1, 4'd7, 1'b0);
        chk("mid_entry_digits", 32'(digits_in), 32'd3);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("mid_entry_reset", 32'(digits_in), 32'd0);

        // Reset mid-lockout.
        for (int n = 0; n < 5 && m_mode != 3; n++) begin
            enter(wrong_code(), 1);
            idle(1);
        end
        idle(5);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("mid_lock_reset_lo", 32'(locked_out), 32'd0);
        chk("mid_lock_reset_fails", 32'(fails), 32'd0);

        // Random soak biased toward the correct digits so every state is visited.
        for (int n = 0; n < 4000; n++) begin
            bit         dv;
            logic [3:0] d;
            dv = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) != 0 && q.size() < 4)
                d = COMBO[15-4*q.size() -: 4];
            else
                d = 4'($urandom);
            step(($urandom_range(0, 599) == 0), dv, d, ($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
